// File: rtl/lbfgs_history_buffer_pkg.sv
// lbfgs_history_buffer_pkg: shared types and sizing helpers for the L-BFGS history buffer.
// Ports: none (package). Provides hist_state_t, float_t and width helpers cnt_w/idx_w.
package lbfgs_pkg;
    localparam int FLOAT_W = 32;
    typedef logic [FLOAT_W-1:0] float_t;
    typedef enum logic {IDLE, SERVE} hist_state_t;
    // Width of a history depth 0..num_loop (CNT_W)
    function automatic int cnt_w(input int num_loop);
        return $clog2(num_loop + 1);
    endfunction
    // Width of a two-loop stream index 0..2*num_loop
    function automatic int idx_w(input int num_loop);
        return $clog2(2 * num_loop + 1);
    endfunction
endpackage

// File: rtl/lbfgs_history_buffer_if.sv
// lbfgs_history_buffer_if: bus between optimizer/SDU (master) and the history buffer (slave).
// Write side: wr_en, s_in, y_in, rho_in -> wr_ready.
// Read side: start, loop_end, s/y/rho_rd_en -> s_out, y_out, rho_out, num_loop_current, busy, rd_error.
interface lbfgs_history_buffer_if
    import lbfgs_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 50,
    parameter int NUM_LOOP     = 10
);
    localparam int VW    = DATA_WIDTH * NUM_ELEMENTS;
    localparam int CNT_W = cnt_w(NUM_LOOP);
    logic                  wr_en;
    logic [VW-1:0]         s_in;
    logic [VW-1:0]         y_in;
    logic [DATA_WIDTH-1:0] rho_in;
    logic                  wr_ready;
    logic                  start;
    logic                  loop_end;
    logic                  s_rd_en;
    logic                  y_rd_en;
    logic                  rho_rd_en;
    logic [VW-1:0]         s_out;
    logic [VW-1:0]         y_out;
    logic [DATA_WIDTH-1:0] rho_out;
    logic [CNT_W-1:0]      num_loop_current;
    logic                  busy;
    logic                  rd_error;
    modport master (
        output wr_en, s_in, y_in, rho_in, start, loop_end, s_rd_en, y_rd_en, rho_rd_en,
        input  wr_ready, s_out, y_out, rho_out, num_loop_current, busy, rd_error
    );
    modport slave (
        input  wr_en, s_in, y_in, rho_in, start, loop_end, s_rd_en, y_rd_en, rho_rd_en,
        output wr_ready, s_out, y_out, rho_out, num_loop_current, busy, rd_error
    );
endinterface

// File: rtl/lbfgs_history_buffer_rd_ptr.sv
// hist_rd_ptr: per-stream two-loop index; maps index j to a storage slot and flags overruns.
// Ports: clk, rst (sync, active-low), clear (rewind), rd_en (gated read request),
//        head/count (buffer state) -> slot (entry to serve), take (read accepted), overrun.
module hist_rd_ptr
    import lbfgs_pkg::*;
#(
    parameter  int NUM_LOOP = 10,
    localparam int HW = $clog2(NUM_LOOP),
    localparam int CW = cnt_w(NUM_LOOP),
    localparam int JW = idx_w(NUM_LOOP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          rd_en,
    input  logic [HW-1:0] head,
    input  logic [CW-1:0] count,
    output logic [HW-1:0] slot,
    output logic          take,
    output logic          overrun
);
    logic [JW-1:0] j, t, c;
    // Biasing by NUM_LOOP keeps t in 0..2*NUM_LOOP-2, so one conditional subtract folds it
    always_comb begin
        c       = JW'(count);
        t       = (j < c) ? JW'(head) + JW'(NUM_LOOP - 1) - j
                          : JW'(head) + JW'(NUM_LOOP) + j - c - c;
        slot    = (t >= JW'(NUM_LOOP)) ? HW'(t - JW'(NUM_LOOP)) : HW'(t);
        take    = rd_en && (j < c + c);
        overrun = rd_en && !take;
    end
    always_ff @(posedge clk)
        if (!rst || clear) j <= '0;
        else if (take) j <= j + JW'(1);
endmodule

// File: rtl/lbfgs_history_buffer.sv
// lbfgs_history_buffer: circular store of the last NUM_LOOP (s, y, rho) pairs served in two-loop order.
// Ports: clk, rst (sync, active-low), bus (lbfgs_history_buffer_if.slave: write port,
//        pass control, three independent read streams, depth/busy/error status).
module lbfgs_history_buffer
    import lbfgs_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 50,
    parameter int NUM_LOOP     = 10
) (
    input logic clk,
    input logic rst,
    lbfgs_history_buffer_if.slave bus
);
    localparam int VW = DATA_WIDTH * NUM_ELEMENTS;
    localparam int HW = $clog2(NUM_LOOP);
    localparam int CW = cnt_w(NUM_LOOP);
    hist_state_t state, state_nxt;
    logic [HW-1:0]         head;
    logic [CW-1:0]         count;
    logic [VW-1:0]         s_mem   [NUM_LOOP];
    logic [VW-1:0]         y_mem   [NUM_LOOP];
    logic [DATA_WIDTH-1:0] rho_mem [NUM_LOOP];
    logic                  wr_fire, rd_gate;
    logic [2:0]            rd_en, take, overrun;
    logic [HW-1:0]         slot [3];
    always_ff @(posedge clk)
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    // start and loop_end both suppress reads: rewind or pass end take priority over a read
    always_comb begin
        state_nxt    = (state == IDLE) ? (bus.start ? SERVE : IDLE) : (bus.loop_end ? IDLE : SERVE);
        bus.wr_ready = (state == IDLE);
        bus.busy     = (state == SERVE);
        wr_fire      = bus.wr_en && (state == IDLE);
        rd_gate      = (state == SERVE) && !bus.start && !bus.loop_end;
        rd_en        = {3{rd_gate}} & {bus.rho_rd_en, bus.y_rd_en, bus.s_rd_en};
    end
    assign bus.num_loop_current = count;
    always_ff @(posedge clk)
        if (!rst) begin
            head  <= '0;
            count <= '0;
        end else if (wr_fire) begin
            head  <= (head == HW'(NUM_LOOP - 1)) ? '0 : head + HW'(1);
            count <= (count == CW'(NUM_LOOP)) ? count : count + CW'(1);
        end
    always_ff @(posedge clk)
        if (wr_fire) begin
            s_mem[head]   <= bus.s_in;
            y_mem[head]   <= bus.y_in;
            rho_mem[head] <= bus.rho_in;
        end
    for (genvar i = 0; i < 3; i++) begin : g_ptr
        hist_rd_ptr #(.NUM_LOOP(NUM_LOOP)) u_ptr (
            .clk(clk), .rst(rst), .clear(bus.start), .rd_en(rd_en[i]),
            .head(head), .count(count), .slot(slot[i]), .take(take[i]), .overrun(overrun[i])
        );
    end
    always_ff @(posedge clk)
        if (!rst) begin
            bus.s_out    <= '0;
            bus.y_out    <= '0;
            bus.rho_out  <= '0;
            bus.rd_error <= 1'b0;
        end else begin
            if (take[0]) bus.s_out <= s_mem[slot[0]];
            if (take[1]) bus.y_out <= y_mem[slot[1]];
            if (take[2]) bus.rho_out <= rho_mem[slot[2]];
            if (bus.start) bus.rd_error <= 1'b0;
            else if (|overrun) bus.rd_error <= 1'b1;
        end
endmodule

// File: tb/tb_lbfgs_history_buffer.sv
// tb_lbfgs_history_buffer: directed and random stimulus checked against a queue-based model.
module tb_lbfgs_history_buffer;
    import lbfgs_pkg::*;
    localparam int DW = 32, NE = 3, NL = 4, VW = DW * NE;
    typedef struct { logic [VW-1:0] s; logic [VW-1:0] y; logic [DW-1:0] rho; } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    lbfgs_history_buffer_if #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE), .NUM_LOOP(NL)) bus();
    lbfgs_history_buffer #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE), .NUM_LOOP(NL)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    pair_t hist[$];
    bit m_serve, m_err;
    int jx[3];
    logic [VW-1:0] m_s, m_y;
    logic [DW-1:0] m_rho;
    float_t rseq[6] = '{32'h40400000, 32'h40000000, 32'h3f800000, 32'h3f800000, 32'h40000000, 32'h40400000};
    float_t sseq[8] = '{32'h40c00000, 32'h40a00000, 32'h40800000, 32'h40400000,
                        32'h40400000, 32'h40800000, 32'h40a00000, 32'h40c00000};

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic pair_t entry(input int j);
        int c = hist.size();
        if (j < c) return hist[c-1-j];
        return hist[j-c];
    endfunction

    task automatic model_read(input int k);
        pair_t p;
        int c = hist.size();
        if (c == 0 || jx[k] >= 2 * c) begin
            m_err = 1;
            return;
        end
        p = entry(jx[k]);
        if (k == 0) m_s = p.s;
        else if (k == 1) m_y = p.y;
        else m_rho = p.rho;
        jx[k]++;
    endtask

    task automatic model_step();
        if (!rst) begin
            m_serve = 0; m_err = 0; hist.delete(); jx = '{0, 0, 0};
            m_s = '0; m_y = '0; m_rho = '0;
        end else if (!m_serve) begin
            if (bus.wr_en) begin
                hist.push_back('{s: bus.s_in, y: bus.y_in, rho: bus.rho_in});
                if (hist.size() > NL) void'(hist.pop_front());
            end
            if (bus.start) begin m_serve = 1; jx = '{0, 0, 0}; m_err = 0; end
        end else begin
            if (bus.start) begin jx = '{0, 0, 0}; m_err = 0; end
            else if (!bus.loop_end) begin
                if (bus.s_rd_en) model_read(0);
                if (bus.y_rd_en) model_read(1);
                if (bus.rho_rd_en) model_read(2);
            end
            if (bus.loop_end) m_serve = 0;
        end
    endtask

    task automatic check_all();
        check("s_out", bus.s_out, m_s);
        check("y_out", bus.y_out, m_y);
        check("rho_out", VW'(bus.rho_out), VW'(m_rho));
        check("num_loop_current", VW'(bus.num_loop_current), VW'(hist.size()));
        check("wr_ready", VW'(bus.wr_ready), VW'(!m_serve));
        check("busy", VW'(bus.busy), VW'(m_serve));
        check("rd_error", VW'(bus.rd_error), VW'(m_err));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        bus.wr_en = 0; bus.start = 0; bus.loop_end = 0;
        bus.s_rd_en = 0; bus.y_rd_en = 0; bus.rho_rd_en = 0;
        check_all();
    endtask

    task automatic load(input logic [DW-1:0] rho);
        for (int k = 0; k < NE; k++) begin
            bus.s_in[k*DW +: DW] = $urandom;
            bus.y_in[k*DW +: DW] = $urandom;
        end
        bus.s_in[DW-1:0] = rho;
        bus.y_in[DW-1:0] = rho ^ 32'h80000000;
        bus.rho_in = rho;
        bus.wr_en = 1;
    endtask

    task automatic write(input logic [DW-1:0] rho);
        load(rho);
        cycle();
    endtask

    task automatic pulse(input bit s, input bit y, input bit r);
        bus.s_rd_en = s; bus.y_rd_en = y; bus.rho_rd_en = r;
        cycle();
    endtask

    task automatic do_reset();
        rst = 0;
        cycle();
        rst = 1;
    endtask

    initial begin
        bus.wr_en = 0; bus.s_in = '0; bus.y_in = '0; bus.rho_in = '0;
        bus.start = 0; bus.loop_end = 0;
        bus.s_rd_en = 0; bus.y_rd_en = 0; bus.rho_rd_en = 0;
        @(negedge clk);
        do_reset();
        // three pairs, rho 1,2,3, then a full rho pass
        write(32'h3f800000); write(32'h40000000); write(32'h40400000);
        check("depth_3", VW'(bus.num_loop_current), VW'(3));
        bus.start = 1; cycle();
        for (int i = 0; i < 6; i++) begin
            pulse(0, 0, 1);
            check("rho_order", VW'(bus.rho_out), VW'(rseq[i]));
        end
        pulse(0, 0, 1);
        check("overrun_hold", VW'(bus.rho_out), VW'(32'h40400000));
        check("overrun_err", VW'(bus.rd_error), VW'(1));
        write(32'h41000000);
        check("serve_wr_drop", VW'(bus.num_loop_current), VW'(3));
        bus.start = 1; cycle();
        check("start_clears_err", VW'(bus.rd_error), VW'(0));
        pulse(1, 1, 1);
        bus.loop_end = 1; cycle();
        // wrap-around: six pairs into four slots
        do_reset();
        for (int i = 1; i <= 6; i++) write(float_t'(32'h3f800000 + 32'h00800000 * (i > 1 ? 1 : 0)) ^ 0 | sseq[(i <= 4) ? 0 : 0] & 0 | (i == 1 ? 32'h3f800000 : i == 2 ? 32'h40000000 : i == 3 ? 32'h40400000 : i == 4 ? 32'h40800000 : i == 5 ? 32'h40a00000 : 32'h40c00000));
        check("depth_full", VW'(bus.num_loop_current), VW'(NL));
        bus.start = 1; cycle();
        for (int i = 0; i < 8; i++) begin
            pulse(1, 0, 0);
            check("s_wrap_order", VW'(bus.s_out[DW-1:0]), VW'(sseq[i]));
        end
        // interleaved streams after a rewind
        bus.start = 1; cycle();
        for (int t = 0; t < 66; t++) pulse(t % 8 == 0, t % 8 == 5, t % 8 == 2);
        bus.loop_end = 1; cycle();
        // write and start in the same idle cycle
        do_reset();
        write(32'h3f800000); write(32'h40000000);
        load(32'h40400000); bus.start = 1; cycle();
        check("wr_start_depth", VW'(bus.num_loop_current), VW'(3));
        for (int i = 0; i < 7; i++) pulse(1, 1, 1);
        check("wr_start_err", VW'(bus.rd_error), VW'(1));
        // reset in the middle of a pass, then a read without start
        bus.start = 1; cycle();
        pulse(1, 1, 1); pulse(1, 1, 1);
        do_reset();
        check("midpass_busy", VW'(bus.busy), VW'(0));
        check("midpass_rho", VW'(bus.rho_out), VW'(0));
        pulse(1, 1, 1);
        check("idle_rd_err", VW'(bus.rd_error), VW'(0));
        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 2) == 0) load($urandom);
            bus.start = ($urandom_range(0, 11) == 0);
            bus.loop_end = ($urandom_range(0, 14) == 0);
            bus.s_rd_en = $urandom_range(0, 1) == 1;
            bus.y_rd_en = $urandom_range(0, 1) == 1;
            bus.rho_rd_en = $urandom_range(0, 1) == 1;
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lbfgs_history_buffer.md
# lbfgs_history_buffer

Circular store of the last NUM_LOOP L-BFGS correction pairs (s_k, y_k, rho_k), serving them to the search-direction unit (SDU) in two-loop order. The optimizer's update stage writes one pair per outer iteration. During direction search the SDU pulses independent s/y/rho read enables. The buffer answers each stream with entries newest→oldest (first loop), then oldest→newest (second loop), and reports the current history depth as num_loop_current.

## Interface
Parameters:
- DATA_WIDTH, 32, IEEE-754 single word width
- NUM_ELEMENTS, 50, vector length
- NUM_LOOP, 10, history capacity (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- wr_en  in  1  write one pair (accepted only when wr_ready=1)
- s_in  in  DATA_WIDTH×NUM_ELEMENTS  new s vector
- y_in  in  DATA_WIDTH×NUM_ELEMENTS  new y vector
- rho_in  in  DATA_WIDTH  new rho
- wr_ready  out  1  high in IDLE
- start  in  1  begin serving a two-loop pass; rewinds all read pointers
- loop_end  in  1  SDU pass finished; return to IDLE
- s_rd_en, y_rd_en, rho_rd_en  in  1 each  advance the respective stream
- s_out, y_out  out  DATA_WIDTH×NUM_ELEMENTS  current s / y entry
- rho_out  out  DATA_WIDTH  current rho entry
- num_loop_current  out  CNT_W  valid entries, 0..NUM_LOOP
- busy  out  1  high in SERVE
- rd_error  out  1  sticky; set by a read overrun or a read of an empty history

## Operation
- States:
  - IDLE: wr_ready=1. start→SERVE. loop_end is ignored.
  - SERVE: wr_ready=0. loop_end→IDLE. start rewinds the pointers and stays in SERVE.
- Write in IDLE:
  - Store the pair at head, head←(head+1) mod NUM_LOOP, count←min(count+1, NUM_LOOP).
  - When full, the oldest pair is overwritten.
  - wr_en in SERVE is dropped; no state change.
- Each stream (s, y, rho) has its own index j, 0..2·count−1, cleared by start:
  - j<count: slot=(head−1−j) mod NUM_LOOP.
  - j≥count: slot=(head−count+(j−count)) mod NUM_LOOP.
  - Modulo is computed by compare/subtract, never a divider.
- rd_en in SERVE with j<2·count: output register ← entry[slot(j)], j←j+1.
- rd_en with j=2·count, or with count=0: outputs and j hold, rd_error←1.
- rd_en in IDLE: ignored, no error.
- num_loop_current=count at all times. start samples nothing; count cannot change in SERVE.
- rd_error clears only on reset or start.

## Timing
- Reset (synchronous, rst=0 at posedge):
  - State IDLE; head=0, count=0; all stream indices 0; rd_error=0.
  - s_out/y_out/rho_out=0; wr_ready=1; busy=0; num_loop_current=0.
  - Storage array is not reset.
- Read latency is 1 cycle: rd_en sampled at edge t, data visible after edge t, held until the next accepted rd_en of that stream.
- Streams are independent. The same-cycle pulses s_rd_en=y_rd_en=rho_rd_en each advance their own stream.
- Write latency is 1 cycle: count and num_loop_current update after the write edge.
- wr_en and start in the same IDLE cycle: the write commits first, and the pass uses the new count and head.
- loop_end and rd_en in the same cycle: the read is ignored, state→IDLE.
- start and rd_en in the same cycle: rewind wins, the read is ignored.
- Reset asserted mid-SERVE: the next cycle is IDLE with all outputs at reset values.

## Structure
- Package lbfgs_pkg:
  - CNT_W=$clog2(NUM_LOOP+1) as a function of NUM_LOOP.
  - State enum hist_state_t {IDLE, SERVE}.
  - Shared float word typedef.
- Sub-module hist_rd_ptr, instantiated three times (s, y, rho):
  - Holds index j and computes the slot from head/count.
  - Flags overrun.
  - Inputs: clk, rst, clear, rd_en, head, count.
- Storage is register arrays; the top holds the FSM, write logic and output registers.

## Test plan
- Reset, then write 3 pairs with rho=1.0,2.0,3.0 (s[0]=rho, y[0]=−rho) → num_loop_current=3; after start, six rho_rd_en pulses give rho_out 3,2,1,1,2,3, each one cycle after its pulse.
- NUM_LOOP=4: write 6 pairs (rho 1..6) → count=4; s stream order is 6,5,4,3,3,4,5,6 (wrap-around overwrite).
- Interleaved pulses (s at t, rho at t+2, y at t+5, repeated) → each stream independently follows the sequence above; no cross-coupling.
- 7th rho_rd_en with count=3 → rho_out holds 3.0 and rd_error=1. A later start → rd_error=0, index rewound.
- wr_en during SERVE → ignored and count unchanged. wr_en+start together in IDLE with count=2 → pass serves 3 entries.
- Reset asserted mid-pass → next cycle busy=0, outputs 0, num_loop_current=0. A subsequent rd_en without start → no change, rd_error=0.
